// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the instruction-memory request/response channel and the
// instruction-to-decode channel of the fetch unit.
//   master : fetch unit side (drives requests and the instruction output)
//   slave  : memory/decode side (drives ready, responses and instr_ready)
// Signals:
//   mem_req_valid/mem_req_ready/mem_req_addr  word read request
//   mem_rsp_valid/mem_rsp_data                read response, one per request
//   instr_valid/instr_ready/instr/instr_pc    instruction handed to decode
//   fetch_err                                 instr is a substituted NOP
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int N  = 32,
  parameter int AW = 10
);
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid;
  logic [N-1:0]  mem_rsp_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [N-1:0]  instr;
  logic [N-1:0]  instr_pc;
  logic          fetch_err;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output instr_valid, instr, instr_pc, fetch_err,
    input  instr_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  instr_valid, instr, instr_pc, fetch_err,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch front end: latches the PC, issues one word read to instruction memory,
// captures the response and holds it for decode. The PC register enable is
// pulsed only when decode takes the instruction, so the PC advances exactly
// once per delivered instruction. Misaligned or out-of-range PCs produce a
// NOP flagged with fetch_err instead of a memory access.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   PC_Value     current PC from the PC register
//   PC_Enable    one-cycle enable pulse to the PC register
//   flush        discard in-flight/held instruction, refetch from PC_Value
//   bus          instr_fetch_unit_if master (memory + decode channels)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int          N         = 32,
  parameter int          AW        = 10,
  parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] PC_Value,
  output logic         PC_Enable,
  input  logic         flush,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t       state;
  logic [N-1:0] fetch_pc;
  logic         drop;

  // Word offset from the start of the text segment, truncated to AW bits.
  function automatic logic [AW-1:0] pc_to_word(input logic [N-1:0] pc);
    logic [N-1:0] off;
    off = pc - N'(TEXT_BASE);
    return off[AW+1:2];
  endfunction

  // Misaligned, below the text base, or beyond the 2^AW-word memory.
  function automatic logic pc_is_bad(input logic [N-1:0] pc);
    logic [N-1:0] off;
    off = pc - N'(TEXT_BASE);
    return (pc[1:0] != 2'b00) || (pc < N'(TEXT_BASE)) || (|off[N-1:AW+2]);
  endfunction

  assign bus.instr_valid = (state == HOLD);
  assign PC_Enable       = (state == HOLD) && bus.instr_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      drop              <= 1'b0;
      fetch_pc          <= '0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_addr  <= '0;
      bus.instr         <= '0;
      bus.instr_pc      <= '0;
      bus.fetch_err     <= 1'b0;
    end else begin
      case (state)
        // Latch the PC; the range check happens here so the request valid
        // can be registered and a bad PC never reaches the memory.
        IDLE: begin
          state             <= REQ;
          fetch_pc          <= PC_Value;
          bus.mem_req_addr  <= pc_to_word(PC_Value);
          bus.mem_req_valid <= !pc_is_bad(PC_Value);
        end

        // mem_req_valid low in REQ means the latched PC was rejected.
        REQ: begin
          if (flush) begin
            bus.mem_req_valid <= 1'b0;
            if (bus.mem_req_valid && bus.mem_req_ready) begin
              state <= WAIT;
              drop  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (!bus.mem_req_valid) begin
            state         <= HOLD;
            bus.instr     <= N'(NOP_INSTR);
            bus.instr_pc  <= fetch_pc;
            bus.fetch_err <= 1'b1;
          end else if (bus.mem_req_ready) begin
            state             <= WAIT;
            bus.mem_req_valid <= 1'b0;
          end
        end

        // A flushed request still owes a response; drop swallows it.
        WAIT: begin
          if (bus.mem_rsp_valid) begin
            drop <= 1'b0;
            if (flush || drop) begin
              state <= IDLE;
            end else begin
              state         <= HOLD;
              bus.instr     <= bus.mem_rsp_data;
              bus.instr_pc  <= fetch_pc;
              bus.fetch_err <= 1'b0;
            end
          end else if (flush) begin
            drop <= 1'b1;
          end
        end

        // Return through IDLE so the PC is resampled after the register
        // has taken the PC_Enable pulse.
        HOLD: begin
          if (flush || bus.instr_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] PC_Value;
  logic        PC_Enable;
  logic        flush;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_unit_if #(.N(32), .AW(10)) bus ();

  instr_fetch_unit #(
    .N(32), .AW(10), .TEXT_BASE(32'h0040_0000), .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .PC_Value (PC_Value),
    .PC_Enable(PC_Enable),
    .flush    (flush),
    .bus      (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hold(input string tag, input logic [31:0] i, input logic [31:0] pc,
                            input logic err);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'h1);
    check({tag, "_instr"}, bus.instr, i);
    check({tag, "_pc"}, bus.instr_pc, pc);
    check({tag, "_err"}, 32'(bus.fetch_err), 32'(err));
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ivalid"}, 32'(bus.instr_valid), 32'h0);
    check({tag, "_rvalid"}, 32'(bus.mem_req_valid), 32'h0);
    check({tag, "_addr"}, 32'(bus.mem_req_addr), 32'h0);
    check({tag, "_instr"}, bus.instr, 32'h0);
    check({tag, "_ipc"}, bus.instr_pc, 32'h0);
    check({tag, "_err"}, 32'(bus.fetch_err), 32'h0);
    check({tag, "_pcen"}, 32'(PC_Enable), 32'h0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; PC_Value = 32'h0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = 32'h0;
    bus.instr_ready = 1'b0;
    step(); step();
    check_reset_outs("rst");

    // Basic fetch: cycle 0 IDLE, 1 REQ, 2 WAIT, 3 HOLD
    reset = 1'b0; PC_Value = 32'h0040_0000; bus.mem_req_ready = 1'b1;
    step();
    check("t1_req_valid", 32'(bus.mem_req_valid), 32'h1);
    check("t1_req_addr", 32'(bus.mem_req_addr), 32'h0);
    step();
    check("t1_wait_rvalid", 32'(bus.mem_req_valid), 32'h0);
    check("t1_wait_ivalid", 32'(bus.instr_valid), 32'h0);
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0050_0093;
    step();
    bus.mem_rsp_valid = 1'b0;
    check_hold("t1", 32'h0050_0093, 32'h0040_0000, 1'b0);
    // decode stalls 5 cycles
    for (int i = 0; i < 5; i++) begin
      check("stall_pcen", 32'(PC_Enable), 32'h0);
      check("stall_rvalid", 32'(bus.mem_req_valid), 32'h0);
      check_hold("stall", 32'h0050_0093, 32'h0040_0000, 1'b0);
      step();
    end
    bus.instr_ready = 1'b1; #1;
    check("t1_pcen_pulse", 32'(PC_Enable), 32'h1);
    step();
    bus.instr_ready = 1'b0; PC_Value = 32'h0040_0010;
    check("t1_pcen_after", 32'(PC_Enable), 32'h0);
    check("t1_idle_ivalid", 32'(bus.instr_valid), 32'h0);

    // Memory not ready for 3 cycles
    bus.mem_req_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check("bp_rvalid", 32'(bus.mem_req_valid), 32'h1);
      check("bp_addr", 32'(bus.mem_req_addr), 32'h4);
      step();
    end
    bus.mem_req_ready = 1'b1;
    check("bp_rvalid4", 32'(bus.mem_req_valid), 32'h1);
    step();
    check("bp_wait_rvalid", 32'(bus.mem_req_valid), 32'h0);
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h00A0_0113;
    step();
    bus.mem_rsp_valid = 1'b0;
    check_hold("bp", 32'h00A0_0113, 32'h0040_0010, 1'b0);
    bus.instr_ready = 1'b1; #1;
    check("bp_pcen", 32'(PC_Enable), 32'h1);
    step();
    bus.instr_ready = 1'b0;

    // Misaligned PC
    PC_Value = 32'h0040_0002;
    step();
    check("mis_rvalid", 32'(bus.mem_req_valid), 32'h0);
    step();
    check_hold("mis", 32'h0000_0013, 32'h0040_0002, 1'b1);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;

    // Below text base
    PC_Value = 32'h0000_1000;
    step();
    check("low_rvalid", 32'(bus.mem_req_valid), 32'h0);
    step();
    check_hold("low", 32'h0000_0013, 32'h0000_1000, 1'b1);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;

    // Last valid word, then flush in WAIT before the response
    PC_Value = 32'h0040_0FFC;
    step();
    check("top_rvalid", 32'(bus.mem_req_valid), 32'h1);
    check("top_addr", 32'(bus.mem_req_addr), 32'h3FF);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; PC_Value = 32'h0040_0020;
    check("fw_ivalid", 32'(bus.instr_valid), 32'h0);
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hDEAD_BEEF;
    step();
    bus.mem_rsp_valid = 1'b0;
    check("fw_discard_ivalid", 32'(bus.instr_valid), 32'h0);
    check("fw_discard_rvalid", 32'(bus.mem_req_valid), 32'h0);
    step();
    check("fw_refetch_rvalid", 32'(bus.mem_req_valid), 32'h1);
    check("fw_refetch_addr", 32'(bus.mem_req_addr), 32'h8);
    step();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0030_0193;
    step();
    bus.mem_rsp_valid = 1'b0;
    check_hold("fw", 32'h0030_0193, 32'h0040_0020, 1'b0);

    // Flush in HOLD overrides instr_ready
    flush = 1'b1; bus.instr_ready = 1'b1; #1;
    check("fh_pcen", 32'(PC_Enable), 32'h0);
    step();
    flush = 1'b0; bus.instr_ready = 1'b0;
    check("fh_ivalid", 32'(bus.instr_valid), 32'h0);

    // One word past the end of memory
    PC_Value = 32'h0040_1000;
    step();
    check("oor_rvalid", 32'(bus.mem_req_valid), 32'h0);
    step();
    check_hold("oor", 32'h0000_0013, 32'h0040_1000, 1'b1);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;

    // Reset while waiting; late response must be ignored
    PC_Value = 32'h0040_0000;
    step();
    check("rw_rvalid", 32'(bus.mem_req_valid), 32'h1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_outs("rw");
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h1234_5678;
    step();
    bus.mem_rsp_valid = 1'b0;
    check("rw_ivalid", 32'(bus.instr_valid), 32'h0);
    check("rw_instr", bus.instr, 32'h0);
    check("rw_req_again", 32'(bus.mem_req_valid), 32'h1);
    step();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0050_0093;
    step();
    bus.mem_rsp_valid = 1'b0;
    check_hold("rw", 32'h0050_0093, 32'h0040_0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch front end that consumes the program counter held by the PC register and drives that register's enable. It reads the current PC, issues a word read to instruction memory over a valid/ready request channel, captures the response, and presents the instruction to decode with a valid/ready handshake. It pulses the PC-register enable only when decode accepts an instruction, so the PC advances exactly once per delivered instruction. Flush and misaligned/out-of-range PC handling are included.

## Interface
- N, 32, data/PC width
- AW, 10, instruction-memory word-address width
- TEXT_BASE, 32'h0040_0000, byte address mapped to memory word 0
- NOP_INSTR, 32'h0000_0013, instruction substituted on fetch error
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high
- PC_Value  in  N  current PC from PC register
- PC_Enable  out  1  enable to PC register; one-cycle pulse per accepted instruction
- flush  in  1  discard in-flight/held instruction; refetch from PC_Value
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  AW  word address = (fetch_pc - TEXT_BASE) >> 2, truncated to AW
- mem_rsp_valid  in  1  read data valid, one cycle per accepted request
- mem_rsp_data  in  N  read data
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode accepts instruction
- instr  out  N  held instruction
- instr_pc  out  N  PC of held instruction
- fetch_err  out  1  held instruction is a substituted NOP due to bad PC

## Operation
- States: IDLE, REQ, WAIT, HOLD. Internal regs: fetch_pc (N), drop (1).
- Reset (sampled on clk edge with reset=1): state=IDLE, drop=0, fetch_pc=0; all outputs 0 (instr=0, instr_pc=0, mem_req_addr=0).
- IDLE: next cycle -> REQ; on that transition latch fetch_pc <= PC_Value.
- REQ entry check on latched fetch_pc: bad if fetch_pc[1:0]!=0, or fetch_pc < TEXT_BASE, or (fetch_pc-TEXT_BASE)>>2 >= 2^AW. If bad: no request issued; next cycle HOLD with instr=NOP_INSTR, instr_pc=fetch_pc, fetch_err=1.
- REQ (good PC): mem_req_valid=1, mem_req_addr held stable until mem_req_ready. On ready -> WAIT.
- WAIT: mem_req_valid=0. On mem_rsp_valid: if drop=1, discard data, clear drop, -> IDLE; else capture instr=mem_rsp_data, instr_pc=fetch_pc, fetch_err=0, -> HOLD.
- HOLD: instr_valid=1, outputs stable. On instr_ready: PC_Enable=1 that cycle, -> IDLE... replaced by direct REQ: next state REQ with fetch_pc <= PC_Value sampled the cycle after the pulse (PC register updated at the pulse edge). Implemented as HOLD -> IDLE -> REQ.
- flush (highest priority over all other events in same cycle):
  - IDLE: no effect.
  - REQ, request not accepted this cycle: drop request, -> IDLE.
  - REQ, accepted same cycle: -> WAIT with drop=1.
  - WAIT, no rsp this cycle: drop=1, stay WAIT. With rsp same cycle: discard, -> IDLE.
  - HOLD: instr_valid deasserted next cycle, no PC_Enable even if instr_ready=1, -> IDLE.
- mem_rsp_valid outside WAIT is ignored. PC_Enable never asserted outside HOLD.
- Reset mid-operation: immediate return to reset state; outstanding memory response after reset ignored (state IDLE).

## Timing
- Cycle 0 after reset release: IDLE. Cycle 1: REQ, mem_req_valid=1.
- Request accepted at edge t -> WAIT from t+1; earliest rsp sampled at t+1; instr_valid at t+2.
- Same-cycle request/response not supported.
- Peak throughput with always-ready memory and decode: one instruction per 4 cycles (IDLE, REQ, WAIT, HOLD).
- PC_Enable is combinational from (state==HOLD & instr_ready & !flush); all other outputs registered or decoded from state.
- Bad-PC path: REQ (1 cycle, no request) -> HOLD.

## Test plan
- Reset then PC_Value=0x0040_0000, memory ready, rsp 1 cycle later with 0x0050_0093 -> mem_req_addr=0, instr_valid at cycle 3 with instr=0x0050_0093, instr_pc=0x0040_0000; instr_ready=1 -> one PC_Enable pulse.
- PC_Value=0x0040_0010, mem_req_ready low 3 cycles -> mem_req_valid held, mem_req_addr=4 stable; accepted on 4th cycle.
- instr_ready held low 5 cycles in HOLD -> instr/instr_pc stable, PC_Enable=0 throughout, no new request.
- PC_Value=0x0040_0002 -> no mem_req_valid; HOLD with instr=0x0000_0013, fetch_err=1; PC_Value=0x0000_1000 gives same.
- flush in WAIT before rsp -> returned data discarded, no instr_valid, new request for current PC_Value; flush in HOLD with instr_ready=1 -> no PC_Enable.
- reset asserted in WAIT, rsp arrives next cycle -> ignored; outputs at reset values, fresh request after release.
